// File: rtl/seg_scan_decoder_pkg.sv
// rtl/seg_scan_decoder_pkg.sv - shared segment patterns, FSM encoding and helpers for the scan decoder
package seg_scan_decoder_pkg;

    localparam int unsigned DEFAULT_STABLE_CYC = 4;

    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;
    localparam logic [6:0] SEG_A = 7'h77;
    localparam logic [6:0] SEG_B = 7'h7C;
    localparam logic [6:0] SEG_C = 7'h39;
    localparam logic [6:0] SEG_D = 7'h5E;
    localparam logic [6:0] SEG_E = 7'h79;
    localparam logic [6:0] SEG_F = 7'h71;

    // Element n holds the pattern that displays hex digit n.
    localparam logic [15:0][6:0] SEG_TABLE = {
        SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
        SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0
    };

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } scan_state_t;

    function automatic logic is_onehot(input logic [3:0] d);
        return (d != 4'd0) && ((d & (d - 4'd1)) == 4'd0);
    endfunction

    function automatic logic [1:0] onehot_idx(input logic [3:0] d);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (d[i]) idx = i[1:0];
        end
        return idx;
    endfunction

endpackage

// File: rtl/seg_pattern_decode.sv
// rtl/seg_pattern_decode.sv - combinational seven-segment pattern to hex nibble decoder
module seg_pattern_decode
    import seg_scan_decoder_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nibble,
    output logic       valid
);

    always_comb begin
        nibble = 4'd0;
        valid  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (seg == SEG_TABLE[i]) begin
                nibble = i[3:0];
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - recovers a 4-digit hex frame from a multiplexed seven-segment scan
module seg_scan_decoder
    import seg_scan_decoder_pkg::*;
#(
    parameter int unsigned STABLE_CYC = DEFAULT_STABLE_CYC
)(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [3:0]  i_dig,
    input  logic [6:0]  i_seg,
    input  logic        i_dp,
    output logic [15:0] o_value,
    output logic [3:0]  o_dp,
    output logic        o_valid,
    output logic        o_err
);

    localparam logic [7:0] STABLE = 8'(STABLE_CYC);

    logic [3:0]       r_dig, p_dig;
    logic [6:0]       r_seg, p_seg;
    logic             r_dp, p_dp;
    logic             changed;

    scan_state_t      state, state_next;
    logic [7:0]       cnt, cnt_next;
    logic             sample;

    logic [3:0][3:0]  slot_val;
    logic [3:0]       slot_dp;
    logic [3:0]       seen, seen_next;
    logic [3:0]       dec_nib;
    logic             dec_ok;
    logic [1:0]       idx;

    assign changed = {r_dig, r_seg, r_dp} != {p_dig, p_seg, p_dp};
    assign idx     = onehot_idx(r_dig);

    seg_pattern_decode u_decode (
        .seg    (r_seg),
        .nibble (dec_nib),
        .valid  (dec_ok)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ST_IDLE;
            cnt   <= 8'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            ST_IDLE: begin
                cnt_next = 8'd0;
                if (is_onehot(r_dig)) begin
                    state_next = ST_SETTLE;
                    cnt_next   = 8'd1;
                end
            end
            ST_SETTLE: begin
                if (!is_onehot(r_dig)) begin
                    state_next = ST_IDLE;
                    cnt_next   = 8'd0;
                end else if (changed) begin
                    cnt_next = 8'd1;
                end else if (cnt != STABLE) begin
                    cnt_next = cnt + 8'd1;
                end
            end
            ST_HOLD: begin
                if (changed) begin
                    state_next = is_onehot(r_dig) ? ST_SETTLE : ST_IDLE;
                    cnt_next   = is_onehot(r_dig) ? 8'd1 : 8'd0;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = 8'd0;
            end
        endcase
        // Reaching the threshold from any path takes the sample this edge.
        if (state_next == ST_SETTLE && cnt_next == STABLE) state_next = ST_HOLD;
    end

    always_comb begin
        sample    = (state != ST_HOLD || changed) && (state_next == ST_HOLD);
        seen_next = (seen == 4'hF) ? 4'h0 : seen;
        if (sample) begin
            if (dec_ok) seen_next = seen_next | r_dig;
            else        seen_next = seen_next & ~r_dig;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_dig    <= 4'd0;
            r_seg    <= 7'd0;
            r_dp     <= 1'b0;
            p_dig    <= 4'd0;
            p_seg    <= 7'd0;
            p_dp     <= 1'b0;
            seen     <= 4'd0;
            slot_val <= '0;
            slot_dp  <= 4'd0;
            o_value  <= 16'h0000;
            o_dp     <= 4'b0000;
            o_valid  <= 1'b0;
            o_err    <= 1'b0;
        end else begin
            r_dig   <= i_dig;
            r_seg   <= i_seg;
            r_dp    <= i_dp;
            p_dig   <= r_dig;
            p_seg   <= r_seg;
            p_dp    <= r_dp;
            seen    <= seen_next;
            o_valid <= 1'b0;
            o_err   <= sample && !dec_ok;
            // Completion publishes the slots as they stood before any same-edge sample.
            if (seen == 4'hF) begin
                o_value <= slot_val;
                o_dp    <= slot_dp;
                o_valid <= 1'b1;
            end
            if (sample && dec_ok) begin
                slot_val[idx] <= dec_nib;
                slot_dp[idx]  <= r_dp;
            end
        end
    end

endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 Parameter STABLE_CYC, default 4: consecutive identical cycles required before a digit is sampled (legal range 1..255).
REQ-002 i_clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 i_rst  input  1  reset; synchronous, active-high.
REQ-004 i_dig  input  4  digit select, one-hot, active-high; bit n selects digit n, with digit 3 most significant.
REQ-005 i_seg  input  7  segment lines, active-high; bit0=a ... bit6=g.
REQ-006 i_dp  input  1  decimal point of the selected digit, active-high.
REQ-007 o_value  output  16  last complete frame; nibble n = digit n.
REQ-008 o_dp  output  4  decimal points of the last complete frame; bit n = digit n.
REQ-009 o_valid  output  1  one-cycle pulse when o_value and o_dp update.
REQ-010 o_err  output  1  one-cycle pulse on a rejected segment pattern.

Function
REQ-011 Decode table: 3F=0, 06=1, 5B=2, 4F=3, 66=4, 6D=5, 7D=6, 07=7, 7F=8, 6F=9, 77=A, 7C=b, 39=C, 5E=d, 79=E, 71=F; every other i_seg value is invalid.
REQ-012 The tuple {i_dig,i_seg,i_dp} is registered once; stability compares each registered tuple against the previous one.
REQ-013 FSM states: IDLE, SETTLE, HOLD.
- IDLE: stability counter = 0.
- IDLE -> SETTLE when the registered i_dig is exactly one-hot.
REQ-014 SETTLE behaviour:
- Counter increments each cycle the tuple is unchanged.
- Any tuple change restarts the counter at 1 (new tuple, still one-hot).
- Non-one-hot i_dig returns the FSM to IDLE.
REQ-015 When the counter reaches STABLE_CYC, the FSM samples once and moves to HOLD.
- Valid pattern: the nibble and dp are stored in the digit-n slot and seen-bit n is set.
- Invalid pattern: o_err pulses on the next cycle and seen-bit n is cleared.
REQ-016 HOLD: no further sampling; any tuple change goes to SETTLE (counter = 1) if one-hot, else to IDLE.
REQ-017 When all four seen-bits are set, on the next cycle:
- o_value and o_dp load the four slots;
- o_valid pulses;
- seen-bits clear.
REQ-018 Re-sampling an already-seen digit before the frame completes overwrites its slot; no error is raised.
REQ-019 Sample-to-o_valid latency: 1 cycle after the last seen-bit sets; input-to-sample: 1 + STABLE_CYC cycles.
REQ-020 If a sample and frame completion coincide, the completing frame uses the slots prior to that sample; the sample goes into the new frame.
REQ-021 The counter saturates at STABLE_CYC and never wraps.
REQ-022 o_value and o_dp hold their values between o_valid pulses.

Reset
REQ-023 While i_rst=1 at a clock edge:
- FSM = IDLE; counter = 0; seen-bits = 0; slots = 0;
- o_value = 16'h0000, o_dp = 4'b0000, o_valid = 0, o_err = 0.
REQ-024 Reset asserted mid-SETTLE or mid-frame discards all partial data; no o_valid or o_err is produced for it.
REQ-025 The first sample after reset release needs a full 1 + STABLE_CYC stable cycles.

Structure
REQ-026 A shared package holds:
- the 16-entry segment pattern constants, also used by the encoder side;
- the FSM state encoding;
- default STABLE_CYC.
REQ-027 Pattern-to-nibble decoding is one sub-module, seg_pattern_decode (7-bit in; 4-bit nibble and 1-bit valid out, combinational).

Verification
REQ-028 Stability and capture (STABLE_CYC=4):
- Stimulus: digits 3,2,1,0 each held 6 cycles with patterns 4F,5B,06,3F.
- Response: o_valid pulse, o_value=16'h3210, o_dp=0.
REQ-029 Short hold:
- Stimulus: digit 0 held 3 cycles with 7F, then digits cycle normally.
- Response: no sample from the short hold; first frame reflects only the later stable values.
REQ-030 Invalid pattern:
- Stimulus: digit 1 shows 0x00 for 6 cycles.
- Response: one o_err pulse; no o_valid until digit 1 is re-presented with a valid pattern.
REQ-031 Non-one-hot select:
- Stimulus: i_dig=4'b0011, then 4'b0000, for 10 cycles each.
- Response: no sample, no o_err, no o_valid.
REQ-032 Reset mid-frame:
- Stimulus: after 3 digits are captured, assert i_rst for 1 cycle, then present only digit 0.
- Response: no o_valid; outputs stay 0.
REQ-033 Decimal points and hex letters:
- Stimulus: frame 71,5E,39,7C with i_dp set on digits 3 and 0.
- Response: o_value=16'hFDCB, o_dp=4'b1001.
